gmii_tx_framer: RTL and testbench

Transmit-side framer that sits directly upstream of the GMII PHY transmit pins (`phy_txd`/`phy_tx_en`/`phy_tx_er`). It accepts an 8-bit AXI-stream frame and emits a complete Ethernet frame on GMII: preamble, SFD, payload, optional padding, CRC-32 FCS, and the enforced inter-frame gap. One byte is emitted per `clk` cycle, at 1000BASE-T rate; the `phy_gtx_clk` domain is `clk`.

---
 rtl/gmii_tx_framer_if.sv | 18 +
 rtl/gmii_tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_framer_if.sv
// rtl/gmii_tx_framer_if.sv - byte stream handshake bundle feeding the GMII transmit framer
interface gmii_tx_framer_if;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic       s_axis_tlast;
   logic       s_axis_tuser;

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready
   );

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready
   );
endinterface

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer (preamble/SFD, payload, pad when GMII_TX_FRAMER_PAD_EN, FCS, IFG)
module gmii_tx_framer #(
   parameter int IFG_BYTES = 12,
   parameter int MIN_FRAME = 60
) (
   input  logic             clk,
   input  logic             rst_n,
   gmii_tx_framer_if.slave  s_axis,
   output logic [7:0]       gmii_txd,
   output logic             gmii_tx_en,
   output logic             gmii_tx_er,
   output logic             tx_start,
   output logic             tx_underflow
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_SFD      = 3'd2;
   localparam logic [2:0] S_DATA     = 3'd3;
   localparam logic [2:0] S_PAD      = 3'd4;
   localparam logic [2:0] S_FCS      = 3'd5;
   localparam logic [2:0] S_IFG      = 3'd6;
   localparam logic [2:0] S_DROP     = 3'd7;

   localparam logic [7:0] L_IFG_LAST = 8'(IFG_BYTES - 1);

   logic [2:0]  r_state;
   logic [2:0]  r_sub;        // preamble byte index, then FCS byte index
   logic [7:0]  r_ifg_cnt;
   logic [31:0] r_crc;
   logic        r_bad;        // tuser latched with tlast

   logic [31:0] w_crc_next;
   logic [31:0] w_fcs;
   logic [7:0]  w_crc_byte;

   // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 8; i++) begin
         x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
      return x;
   endfunction

   assign s_axis.s_axis_tready = (r_state == S_SFD) || (r_state == S_DATA) || (r_state == S_DROP);
   assign w_crc_byte = (r_state == S_PAD) ? 8'h00 : s_axis.s_axis_tdata;
   assign w_crc_next = crc_byte(r_crc, w_crc_byte);
   assign w_fcs      = ~r_crc;

`ifdef GMII_TX_FRAMER_PAD_EN
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_next;
   logic        w_short;

   // SFD takes the first byte, so the count restarts at one there; saturates at 0xFFFF
   assign w_cnt_next = (r_state == S_SFD) ? 16'd1 :
                       (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   assign w_short    = w_cnt_next < 16'(MIN_FRAME);
`else
   logic [15:0] w_unused_min_frame;
   assign w_unused_min_frame = 16'(MIN_FRAME);
`endif

   // Frame sequencer; every GMII output is loaded here so the pins are registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_sub        <= 3'd0;
         r_ifg_cnt    <= 8'd0;
         r_crc        <= 32'hFFFFFFFF;
         r_bad        <= 1'b0;
         gmii_txd     <= 8'h00;
         gmii_tx_en   <= 1'b0;
         gmii_tx_er   <= 1'b0;
         tx_start     <= 1'b0;
         tx_underflow <= 1'b0;
`ifdef GMII_TX_FRAMER_PAD_EN
         r_cnt        <= 16'd0;
`endif
      end else begin
         tx_start     <= 1'b0;
         tx_underflow <= 1'b0;
         gmii_tx_er   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               gmii_txd   <= 8'h00;
               gmii_tx_en <= 1'b0;
               if (s_axis.s_axis_tvalid) begin
                  r_state <= S_PREAMBLE;
                  r_sub   <= 3'd0;
                  r_crc   <= 32'hFFFFFFFF;
               end
            end
            S_PREAMBLE: begin
               // Seven 0x55 bytes, the eighth slot loads the SFD
               gmii_tx_en <= 1'b1;
               r_sub      <= r_sub + 3'd1;
               if (r_sub == 3'd0) begin
                  tx_start <= 1'b1;
               end
               if (r_sub == 3'd7) begin
                  gmii_txd <= 8'hD5;
                  r_state  <= S_SFD;
               end else begin
                  gmii_txd <= 8'h55;
               end
            end
            S_SFD, S_DATA: begin
               gmii_tx_en <= 1'b1;
               if (s_axis.s_axis_tvalid) begin
                  gmii_txd <= s_axis.s_axis_tdata;
                  r_crc    <= w_crc_next;
`ifdef GMII_TX_FRAMER_PAD_EN
                  r_cnt    <= w_cnt_next;
`endif
                  if (s_axis.s_axis_tlast) begin
                     r_bad <= s_axis.s_axis_tuser;
                     r_sub <= 3'd0;
`ifdef GMII_TX_FRAMER_PAD_EN
                     r_state <= w_short ? S_PAD : S_FCS;
`else
                     r_state <= S_FCS;
`endif
                  end else begin
                     r_state <= S_DATA;
                  end
               end else begin
                  // Source ran dry mid-frame: poison the wire for one byte and abandon
                  gmii_txd     <= 8'h00;
                  gmii_tx_er   <= 1'b1;
                  tx_underflow <= 1'b1;
                  r_state      <= S_DROP;
               end
            end
`ifdef GMII_TX_FRAMER_PAD_EN
            S_PAD: begin
               gmii_txd   <= 8'h00;
               gmii_tx_en <= 1'b1;
               r_crc      <= w_crc_next;
               r_cnt      <= w_cnt_next;
               if (w_cnt_next == 16'(MIN_FRAME)) begin
                  r_state <= S_FCS;
               end
            end
`endif
            S_FCS: begin
               gmii_txd   <= w_fcs[{r_sub[1:0], 3'b000} +: 8];
               gmii_tx_en <= 1'b1;
               gmii_tx_er <= r_bad;
               r_sub      <= r_sub + 3'd1;
               if (r_sub == 3'd3) begin
                  r_state   <= S_IFG;
                  r_ifg_cnt <= 8'd0;
               end
            end
            S_IFG: begin
               gmii_txd   <= 8'h00;
               gmii_tx_en <= 1'b0;
               if (r_ifg_cnt == L_IFG_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_ifg_cnt <= r_ifg_cnt + 8'd1;
               end
            end
            S_DROP: begin
               gmii_txd   <= 8'h00;
               gmii_tx_en <= 1'b0;
               if (s_axis.s_axis_tvalid && s_axis.s_axis_tlast) begin
                  r_state   <= S_IFG;
                  r_ifg_cnt <= 8'd0;
               end
            end
            default: begin
               gmii_txd   <= 8'h00;
               gmii_tx_en <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - scoreboard bench for gmii_tx_framer
`timescale 1ns/1ps
module tb_gmii_tx_framer;

   localparam int IFG = 12;
`ifdef GMII_TX_FRAMER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       tx_start;
   logic       tx_underflow;

   gmii_tx_framer_if axis ();

   gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(60)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axis       (axis),
      .gmii_txd     (gmii_txd),
      .gmii_tx_en   (gmii_tx_en),
      .gmii_tx_er   (gmii_tx_er),
      .tx_start     (tx_start),
      .tx_underflow (tx_underflow)
   );

   always #4 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0]   exp_q[$];     // {tx_er, txd} for every tx_en cycle
   byte unsigned frame[$];

   int   cyc = 0;
   int   starts = 0;
   int   underflows = 0;
   int   start_cyc = -1;
   int   gap = 0;
   int   last_gap = -1;
   int   run = 0;
   int   last_run = -1;
   logic prev_en = 1'b0;
   logic [8:0] mon_e;

   always @(posedge clk) cyc++;

   // Wire monitor: pops the scoreboard on every transmitted byte
   always @(negedge clk) begin
      if (gmii_tx_en === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wire_extra: got er=%b txd=%02h, required no transmission", gmii_tx_er, gmii_txd);
         end else begin
            mon_e = exp_q.pop_front();
            if ({gmii_tx_er, gmii_txd} !== mon_e) begin
               n_fail++;
               $display("FAIL wire_byte: got er=%b txd=%02h, required er=%b txd=%02h",
                        gmii_tx_er, gmii_txd, mon_e[8], mon_e[7:0]);
            end
         end
         if (prev_en !== 1'b1) last_gap = gap;
         gap = 0;
         run++;
      end else begin
         gap++;
         if (run > 0) last_run = run;
         run = 0;
      end
      if (tx_start === 1'b1) begin
         starts++;
         start_cyc = cyc;
         n_tests++;
         if (!(gmii_tx_en === 1'b1 && gmii_txd === 8'h55 && prev_en !== 1'b1)) begin
            n_fail++;
            $display("FAIL tx_start_align: got en=%b txd=%02h prev_en=%b, required first 0x55 after idle",
                     gmii_tx_en, gmii_txd, prev_en);
         end
      end
      if (tx_underflow === 1'b1) underflows++;
      prev_en = gmii_tx_en;
   end

   task automatic set_frame(input int n, input int base);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(8'(base + i));
   endtask

   // cut >= 0 keeps only the first cut payload bytes; cut_err adds the underflow byte
   task automatic push_expected(input bit tuser, input int cut, input bit cut_err);
      byte unsigned pl[$];
      logic [31:0]  c;
      for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'hD5});
      if (cut >= 0) begin
         for (int i = 0; i < cut; i++) exp_q.push_back({1'b0, frame[i]});
         if (cut_err) exp_q.push_back({1'b1, 8'h00});
         return;
      end
      pl = frame;
      if (PAD) while (pl.size() < 60) pl.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (pl[i]) begin
         c = c ^ {24'h0, pl[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      foreach (pl[i]) exp_q.push_back({1'b0, pl[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({tuser, c[8*k +: 8]});
   endtask

   function automatic int wire_len(input int n);
      return 8 + ((PAD && n < 60) ? 60 : n) + 4;
   endfunction

   task automatic drive_frame(input bit tuser, input int stall_after, input int max_accept, output bit ok);
      int i = 0;
      int guard = 0;
      bit stalled = 1'b0;
      bit rdy;
      while (i < frame.size() && i != max_accept && guard < 4000) begin
         if (i == stall_after && !stalled) begin
            axis.s_axis_tvalid = 1'b0;
            axis.s_axis_tlast  = 1'b0;
            stalled = 1'b1;
            @(posedge clk); #1;
         end else begin
            axis.s_axis_tvalid = 1'b1;
            axis.s_axis_tdata  = frame[i];
            axis.s_axis_tlast  = (i == frame.size() - 1);
            axis.s_axis_tuser  = tuser && (i == frame.size() - 1);
            rdy = axis.s_axis_tready;
            @(posedge clk); #1;
            if (rdy) i++;
         end
         guard++;
      end
      axis.s_axis_tvalid = 1'b0;
      axis.s_axis_tlast  = 1'b0;
      axis.s_axis_tuser  = 1'b0;
      ok = (i == frame.size()) || (i == max_accept);
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 2000) begin
         @(posedge clk);
         g++;
      end
      repeat (IFG + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({gmii_txd, gmii_tx_en, gmii_tx_er, tx_start, tx_underflow} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got txd=%02h en=%b er=%b start=%b uf=%b, required all 0",
                  gmii_txd, gmii_tx_en, gmii_tx_er, tx_start, tx_underflow);
      end
      n_tests++;
      if (axis.s_axis_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tready: got %b, required 0", axis.s_axis_tready);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (axis.s_axis_tready !== 1'b0 || gmii_tx_en !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: got tready=%b en=%b, required 0 0", axis.s_axis_tready, gmii_tx_en);
      end
   endtask

   task automatic test_check_value();
      bit ok;
      int p;
      set_frame(9, 8'h31);
      if (PAD) begin
         push_expected(1'b0, -1, 1'b0);
      end else begin
         for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
         exp_q.push_back({1'b0, 8'hD5});
         for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 8'(8'h31 + i)});
         exp_q.push_back({1'b0, 8'h26});
         exp_q.push_back({1'b0, 8'h39});
         exp_q.push_back({1'b0, 8'hF4});
         exp_q.push_back({1'b0, 8'hCB});
      end
      p = cyc;
      drive_frame(1'b0, -1, -1, ok);
      drain();
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL check_accept: got incomplete, required 9 bytes accepted"); end
      n_tests++;
      if (start_cyc != p + 2) begin
         n_fail++;
         $display("FAIL start_latency: got cycle %0d, required %0d", start_cyc, p + 2);
      end
      n_tests++;
      if (last_run != wire_len(9)) begin
         n_fail++;
         $display("FAIL check_span: got %0d, required %0d", last_run, wire_len(9));
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL check_drain: got %0d bytes outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_short_frames();
      bit ok;
      int lens[3] = '{14, 1, 60};
      foreach (lens[k]) begin
         set_frame(lens[k], 8'h10 * (k + 1));
         push_expected(1'b0, -1, 1'b0);
         drive_frame(1'b0, -1, -1, ok);
         drain();
         n_tests++;
         if (!ok || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL short_%0d_drain: got ok=%b outstanding=%0d, required 1 0", lens[k], ok, exp_q.size());
         end
         n_tests++;
         if (last_run != wire_len(lens[k])) begin
            n_fail++;
            $display("FAIL short_%0d_span: got %0d, required %0d", lens[k], last_run, wire_len(lens[k]));
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok1;
      bit ok2;
      int s0;
      s0 = starts;
      set_frame(64, 8'h40);
      push_expected(1'b0, -1, 1'b0);
      drive_frame(1'b0, -1, -1, ok1);
      set_frame(64, 8'h90);
      push_expected(1'b0, -1, 1'b0);
      drive_frame(1'b0, -1, -1, ok2);
      drain();
      n_tests++;
      if (!ok1 || !ok2 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got ok=%b%b outstanding=%0d, required 11 0", ok1, ok2, exp_q.size());
      end
      n_tests++;
      if (last_gap != IFG + 1) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d idle cycles, required %0d", last_gap, IFG + 1);
      end
      n_tests++;
      if (starts - s0 != 2) begin
         n_fail++;
         $display("FAIL b2b_starts: got %0d, required 2", starts - s0);
      end
   endtask

   task automatic test_underflow();
      bit ok;
      int u0;
      u0 = underflows;
      set_frame(64, 8'h20);
      push_expected(1'b0, 10, 1'b1);
      drive_frame(1'b0, 10, -1, ok);
      drain();
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL uf_discard: got incomplete, required 64 bytes accepted"); end
      n_tests++;
      if (underflows - u0 != 1) begin
         n_fail++;
         $display("FAIL uf_pulse: got %0d pulses, required 1", underflows - u0);
      end
      n_tests++;
      if (last_run != 19 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL uf_wire: got span=%0d outstanding=%0d, required 19 0", last_run, exp_q.size());
      end
   endtask

   task automatic test_bad_frame();
      bit ok;
      set_frame(20, 8'hA0);
      push_expected(1'b1, -1, 1'b0);
      drive_frame(1'b1, -1, -1, ok);
      drain();
      n_tests++;
      if (!ok || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bad_drain: got ok=%b outstanding=%0d, required 1 0", ok, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      set_frame(30, 8'h60);
      push_expected(1'b0, 5, 1'b0);
      drive_frame(1'b0, -1, 5, ok);
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({gmii_txd, gmii_tx_en, gmii_tx_er, tx_start, tx_underflow, axis.s_axis_tready} !== 13'h0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got txd=%02h en=%b er=%b start=%b uf=%b rdy=%b, required all 0",
                  gmii_txd, gmii_tx_en, gmii_tx_er, tx_start, tx_underflow, axis.s_axis_tready);
      end
      n_tests++;
      if (!ok || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_partial: got ok=%b outstanding=%0d, required 1 0", ok, exp_q.size());
      end
      rst_n = 1'b1;
      set_frame(25, 8'hC0);
      push_expected(1'b0, -1, 1'b0);
      drive_frame(1'b0, -1, -1, ok);
      drain();
      n_tests++;
      if (!ok || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_next: got ok=%b outstanding=%0d, required 1 0", ok, exp_q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      axis.s_axis_tdata  = 8'h00;
      axis.s_axis_tvalid = 1'b0;
      axis.s_axis_tlast  = 1'b0;
      axis.s_axis_tuser  = 1'b0;
      test_reset();
      test_check_value();
      test_short_frames();
      test_back_to_back();
      test_underflow();
      test_bad_frame();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
